counter_mod_n: RTL and testbench

//   Parametrised modulo-N up/down counter. Supports synchronous load, count enable,

---
 rtl/counter_mod_n_pkg.sv | 34 +++
 rtl/counter_mod_n.sv | 88 ++++++++
 tb/tb_counter_mod_n.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_mod_n_pkg.sv
// Shared types and helpers for the modulo-N counter family.
package counter_mod_n_pkg;

   // Behaviour at the range ends.
   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   // Count direction as carried on the UP pin.
   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // Action taken on the next clock edge.
   typedef enum logic [2:0] {
      OP_HOLD,
      OP_CLEAR,
      OP_LOAD,
      OP_INC,
      OP_DEC,
      OP_TO_ZERO,
      OP_TO_MAX,
      OP_SAT_LOW
   } op_e;

   // Legal when 2 <= modulus <= 2**width.
   function automatic bit modulus_ok(input int unsigned width, input int unsigned modulus);
      if (width == 0 || width > 31) return 1'b0;
      return (modulus >= 2) && (modulus <= (32'd1 << width));
   endfunction

endpackage

// File: rtl/counter_mod_n.sv
// Parametrised modulo-N up/down counter with load, enable, wrap/saturate
// mode, combinational cascade terminal count and a sticky DONE flag.
module counter_mod_n
   import counter_mod_n_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULUS  = 10,
   parameter int unsigned SATURATE = 0
) (
   input  logic             CLK,
   input  logic             CLEAR,
   input  logic             EN,
   input  logic             UP,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             ZERO,
   output logic             DONE
);

   localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);
   localparam mode_e            MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

   if (!modulus_ok(WIDTH, MODULUS)) begin : g_param_check
      $error("counter_mod_n: illegal parameters WIDTH=%0d MODULUS=%0d", WIDTH, MODULUS);
   end

   dir_e             dir;
   logic             at_top;
   logic             at_bot;
   logic             end_hit;
   logic [WIDTH-1:0] load_q;
   op_e              op;

   assign dir     = dir_e'(UP);
   assign at_top  = (Q == QMAX);
   assign at_bot  = (Q == '0);
   assign end_hit = (dir == DIR_UP) ? at_top : at_bot;

   // Comparing against QMAX instead of MODULUS keeps the test inside WIDTH
   // bits, so MODULUS == 2**WIDTH simply never clamps.
   assign load_q  = (LOAD_VAL > QMAX) ? QMAX : LOAD_VAL;

   assign TC      = EN & ~CLEAR & ~LOAD & end_hit;
   assign ZERO    = at_bot;

   // Decode the edge action with CLEAR > LOAD > EN priority.
   always_comb begin
      op = OP_HOLD;
      if (CLEAR) begin
         op = OP_CLEAR;
      end else if (LOAD) begin
         op = OP_LOAD;
      end else if (EN) begin
         if (dir == DIR_UP) begin
            if (!at_top)               op = OP_INC;
            else if (MODE == MODE_SAT) op = OP_HOLD;
            else                       op = OP_TO_ZERO;
         end else begin
            if (!at_bot)               op = OP_DEC;
            else if (MODE == MODE_SAT) op = OP_SAT_LOW;
            else                       op = OP_TO_MAX;
         end
      end
   end

   // Count register and sticky DONE flag.
   always_ff @(posedge CLK) begin
      case (op)
         OP_CLEAR: begin
            Q    <= '0;
            DONE <= 1'b0;
         end
         OP_LOAD: begin
            Q    <= load_q;
            DONE <= 1'b0;
         end
         OP_INC:     Q    <= Q + WIDTH'(1);
         OP_DEC:     Q    <= Q - WIDTH'(1);
         OP_TO_ZERO: Q    <= '0;
         OP_TO_MAX:  Q    <= QMAX;
         OP_SAT_LOW: DONE <= 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_counter_mod_n.sv
// Self-checking bench for counter_mod_n: table-driven vectors on a mod-10
// wrap counter plus hand sequences for mod-8 rollover, saturation and a
// units/tens cascade.
module tb_counter_mod_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- main DUT: WIDTH=4, MODULUS=10, wrap ----------------
   logic       m_clear = 1'b1, m_en = 1'b0, m_up = 1'b1, m_load = 1'b0;
   logic [3:0] m_lv = '0;
   logic [3:0] m_q;
   logic       m_tc, m_zero, m_done;

   counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u10 (
      .CLK(clk), .CLEAR(m_clear), .EN(m_en), .UP(m_up), .LOAD(m_load),
      .LOAD_VAL(m_lv), .Q(m_q), .TC(m_tc), .ZERO(m_zero), .DONE(m_done));

   // ---------------- WIDTH=3, MODULUS=8 (natural rollover) ----------------
   logic       e_clear = 1'b1, e_en = 1'b0, e_up = 1'b1, e_load = 1'b0;
   logic [2:0] e_lv = '0;
   logic [2:0] e_q;
   logic       e_tc, e_zero, e_done;

   counter_mod_n #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u8 (
      .CLK(clk), .CLEAR(e_clear), .EN(e_en), .UP(e_up), .LOAD(e_load),
      .LOAD_VAL(e_lv), .Q(e_q), .TC(e_tc), .ZERO(e_zero), .DONE(e_done));

   // ---------------- saturating mod-10 ----------------
   logic       s_clear = 1'b1, s_en = 1'b0, s_up = 1'b0, s_load = 1'b0;
   logic [3:0] s_lv = '0;
   logic [3:0] s_q;
   logic       s_tc, s_zero, s_done;

   counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) usat (
      .CLK(clk), .CLEAR(s_clear), .EN(s_en), .UP(s_up), .LOAD(s_load),
      .LOAD_VAL(s_lv), .Q(s_q), .TC(s_tc), .ZERO(s_zero), .DONE(s_done));

   // ---------------- cascade: units mod 10 -> tens mod 6 ----------------
   logic       c_clear = 1'b1, c_en = 1'b0, c_up = 1'b1, c_load = 1'b0;
   logic [3:0] cu_lv = '0;
   logic [2:0] ct_lv = '0;
   logic [3:0] cu_q;
   logic [2:0] ct_q;
   logic       cu_tc, cu_zero, cu_done, ct_tc, ct_zero, ct_done;

   counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_units (
      .CLK(clk), .CLEAR(c_clear), .EN(c_en), .UP(c_up), .LOAD(c_load),
      .LOAD_VAL(cu_lv), .Q(cu_q), .TC(cu_tc), .ZERO(cu_zero), .DONE(cu_done));

   counter_mod_n #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u_tens (
      .CLK(clk), .CLEAR(c_clear), .EN(cu_tc), .UP(c_up), .LOAD(c_load),
      .LOAD_VAL(ct_lv), .Q(ct_q), .TC(ct_tc), .ZERO(ct_zero), .DONE(ct_done));

   // One cycle per record: tc is the pre-edge value, q/done the post-edge value.
   typedef struct {
      string      name;
      logic       clear, en, up, load;
      logic [3:0] lv;
      logic       tc;
      logic [3:0] q;
      logic       done;
   } vec_t;

   vec_t vecs[$];

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      m_clear = v.clear; m_en = v.en; m_up = v.up; m_load = v.load; m_lv = v.lv;
      #1;
      check({v.name, ".tc"}, m_tc, v.tc);
      @(posedge clk);
      #1;
      check({v.name, ".q"},    m_q,    v.q);
      check({v.name, ".zero"}, m_zero, (v.q == 4'd0) ? 1 : 0);
      check({v.name, ".done"}, m_done, v.done);
   endtask

   initial begin
      int unsigned pre_q, post_q;
      int          sat_pre[6]  = '{3, 2, 1, 0, 0, 0};
      int          sat_post[6] = '{2, 1, 0, 0, 0, 0};
      int          sat_done[6] = '{0, 0, 0, 1, 1, 1};

      //            name         clr en up ld lv  tc q  done
      vecs.push_back('{"rst1",      1, 1, 1, 0, 0,  0, 0, 0});
      vecs.push_back('{"rst2",      1, 1, 0, 0, 0,  0, 0, 0});
      vecs.push_back('{"ld2",       0, 0, 0, 1, 2,  0, 2, 0});
      vecs.push_back('{"dn1",       0, 1, 0, 0, 0,  0, 1, 0});
      vecs.push_back('{"dn0",       0, 1, 0, 0, 0,  0, 0, 0});
      vecs.push_back('{"dnwrap",    0, 1, 0, 0, 0,  1, 9, 0});
      vecs.push_back('{"dn8",       0, 1, 0, 0, 0,  0, 8, 0});
      vecs.push_back('{"ldclamp15", 0, 0, 1, 1, 15, 0, 9, 0});
      vecs.push_back('{"upwrap",    0, 1, 1, 0, 0,  1, 0, 0});
      vecs.push_back('{"up1",       0, 1, 1, 0, 0,  0, 1, 0});
      vecs.push_back('{"hold",      0, 0, 1, 0, 0,  0, 1, 0});
      vecs.push_back('{"clrprio",   1, 1, 1, 1, 5,  0, 0, 0});
      vecs.push_back('{"ldprio",    0, 1, 0, 1, 9,  0, 9, 0});
      vecs.push_back('{"holdtop",   0, 0, 1, 0, 0,  0, 9, 0});
      vecs.push_back('{"dirchg",    0, 1, 0, 0, 0,  0, 8, 0});
      vecs.push_back('{"up9",       0, 1, 1, 0, 0,  0, 9, 0});
      vecs.push_back('{"clrmid",    1, 1, 1, 0, 0,  0, 0, 0});
      vecs.push_back('{"ldclamp10", 0, 0, 0, 1, 10, 0, 9, 0});
      vecs.push_back('{"ld0",       0, 0, 0, 1, 0,  0, 0, 0});

      foreach (vecs[i]) run_vec(vecs[i]);
      @(negedge clk);
      m_en = 1'b0; m_load = 1'b0; m_clear = 1'b0;

      // Mod-8 rollover at the natural 3-bit boundary.
      pre_q = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         e_clear = 1'b0; e_en = 1'b1; e_up = 1'b1;
         #1;
         check($sformatf("up8[%0d].tc", i), e_tc, (pre_q == 7) ? 1 : 0);
         @(posedge clk);
         #1;
         post_q = (pre_q + 1) % 8;
         check($sformatf("up8[%0d].q", i), e_q, post_q);
         pre_q = post_q;
      end
      @(negedge clk);
      e_en = 1'b0;

      // Saturating count-down and sticky DONE.
      s_clear = 1'b0; s_load = 1'b1; s_lv = 4'd3;
      @(posedge clk);
      #1;
      check("sat.ld3.q", s_q, 3);
      check("sat.ld3.done", s_done, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         s_load = 1'b0; s_en = 1'b1; s_up = 1'b0;
         #1;
         check($sformatf("sat[%0d].tc", i), s_tc, (sat_pre[i] == 0) ? 1 : 0);
         @(posedge clk);
         #1;
         check($sformatf("sat[%0d].q", i), s_q, sat_post[i]);
         check($sformatf("sat[%0d].done", i), s_done, sat_done[i]);
      end
      @(negedge clk);
      s_en = 1'b0;
      @(posedge clk);
      #1;
      check("sat.idle.done", s_done, 1);
      @(negedge clk);
      s_load = 1'b1; s_lv = 4'd5;
      @(posedge clk);
      #1;
      check("sat.ld5.q", s_q, 5);
      check("sat.ld5.done", s_done, 0);
      @(negedge clk);
      s_lv = 4'd9;
      @(posedge clk);
      @(negedge clk);
      s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
      #1;
      check("sat.top.tc", s_tc, 1);
      @(posedge clk);
      #1;
      check("sat.top.q", s_q, 9);
      check("sat.top.done", s_done, 0);
      @(negedge clk);
      s_en = 1'b0;

      // Cascade 59 -> 00 -> 59 -> 58.
      c_clear = 1'b0; c_load = 1'b1; cu_lv = 4'd9; ct_lv = 3'd5;
      @(posedge clk);
      #1;
      check("casc.ld.units", cu_q, 9);
      check("casc.ld.tens", ct_q, 5);
      @(negedge clk);
      c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
      #1;
      check("casc.up.units_tc", cu_tc, 1);
      check("casc.up.tens_tc", ct_tc, 1);
      @(posedge clk);
      #1;
      check("casc.up.units", cu_q, 0);
      check("casc.up.tens", ct_q, 0);
      @(negedge clk);
      c_up = 1'b0;
      #1;
      check("casc.dn.units_tc", cu_tc, 1);
      check("casc.dn.tens_tc", ct_tc, 1);
      @(posedge clk);
      #1;
      check("casc.dn.units", cu_q, 9);
      check("casc.dn.tens", ct_q, 5);
      @(negedge clk);
      #1;
      check("casc.dn2.units_tc", cu_tc, 0);
      @(posedge clk);
      #1;
      check("casc.dn2.units", cu_q, 8);
      check("casc.dn2.tens", ct_q, 5);
      @(negedge clk);
      c_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
